weight_update_engine: RTL and testbench



---
 rtl/weight_update_engine.sv | 137 +++++++++++++
 tb/tb_weight_update_engine.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update_engine.sv
// Weight update engine: applies w[k] -= ((error * act[k] * rate_mul) >>> rate_shift) over a
// bank of COUNT signed weights through a two-stage pipeline, with optional saturation.
module weight_update_engine #(
    parameter int WIDTH    = 32,
    parameter int COUNT    = 8,
    parameter int SATURATE = 1
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic signed [WIDTH-1:0]                        error,
    input  logic        [COUNT*WIDTH-1:0]                  act,
    input  logic signed [WIDTH-1:0]                        rate_mul,
    input  logic        [$clog2(3*WIDTH)-1:0]              rate_shift,
    input  logic                                           load_en,
    input  logic        [((COUNT > 1) ? $clog2(COUNT) : 1)-1:0] load_idx,
    input  logic        [WIDTH-1:0]                        load_data,
    output logic        [COUNT*WIDTH-1:0]                  weights,
    output logic                                           done,
    output logic                                           sat_flag
);

    localparam int PW = 2 * WIDTH;
    localparam int DW = 3 * WIDTH;
    localparam int SW = $clog2(3 * WIDTH);
    localparam int IW = (COUNT > 1) ? $clog2(COUNT) : 1;
    localparam int CW = $clog2(COUNT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                  state_q;
    logic signed [WIDTH-1:0] error_q, rate_mul_q;
    logic [COUNT*WIDTH-1:0]  act_q;
    logic [SW-1:0]           shift_q;
    logic [CW-1:0]           cnt_q;
    logic signed [PW-1:0]    p_q;
    logic [IW-1:0]           p_idx_q;
    logic                    p_vld_q;
    logic signed [WIDTH-1:0] bank_q [COUNT];
    logic                    done_q, sat_q;

    logic signed [WIDTH-1:0] act_k, w_old, w_new;
    logic signed [PW-1:0]    p_next;
    logic signed [DW-1:0]    prod, delta;
    logic signed [DW:0]      diff;
    logic                    fits, sat_now;

    always_comb begin
        act_k = '0;
        for (int i = 0; i < COUNT; i++) begin
            if (cnt_q == CW'(i)) act_k = act_q[i*WIDTH +: WIDTH];
        end
        p_next = $signed({{WIDTH{error_q[WIDTH-1]}}, error_q}) *
                 $signed({{WIDTH{act_k[WIDTH-1]}}, act_k});
        prod   = $signed({{WIDTH{p_q[PW-1]}}, p_q}) *
                 $signed({{PW{rate_mul_q[WIDTH-1]}}, rate_mul_q});
        delta  = prod >>> shift_q;
        w_old  = bank_q[p_idx_q];
        // One extra bit so the subtraction itself can never overflow.
        diff   = $signed({{(DW + 1 - WIDTH){w_old[WIDTH-1]}}, w_old}) -
                 $signed({delta[DW-1], delta});
        fits    = (&diff[DW:WIDTH-1]) || !(|diff[DW:WIDTH-1]);
        sat_now = (SATURATE != 0) && !fits;
        if (sat_now) begin
            w_new = diff[DW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_new = diff[WIDTH-1:0];
        end
    end

    for (genvar g = 0; g < COUNT; g++) begin : g_pack
        assign weights[g*WIDTH +: WIDTH] = bank_q[g];
    end

    assign in_ready = (state_q == StIdle) && !reset;
    assign done     = done_q;
    assign sat_flag = sat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            error_q    <= '0;
            rate_mul_q <= '0;
            act_q      <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            p_q        <= '0;
            p_idx_q    <= '0;
            p_vld_q    <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
            for (int i = 0; i < COUNT; i++) bank_q[i] <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (load_en && (int'(load_idx) < COUNT)) bank_q[load_idx] <= load_data;
                    if (in_valid) begin
                        error_q    <= error;
                        rate_mul_q <= rate_mul;
                        act_q      <= act;
                        shift_q    <= rate_shift;
                        sat_q      <= 1'b0;
                        cnt_q      <= '0;
                        p_vld_q    <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    if (int'(cnt_q) < COUNT) begin
                        p_q     <= p_next;
                        p_idx_q <= cnt_q[IW-1:0];
                        p_vld_q <= 1'b1;
                        cnt_q   <= cnt_q + 1'b1;
                    end else begin
                        p_vld_q <= 1'b0;
                    end
                    if (p_vld_q) begin
                        bank_q[p_idx_q] <= w_new;
                        if (sat_now) sat_q <= 1'b1;
                        if (p_idx_q == IW'(COUNT - 1)) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_update_engine.sv
// Bench for weight_update_engine: saturating and wrapping instances checked every cycle
// against a cycle-numbered arithmetic model, plus literal expectations and an index-bound probe.
module tb_weight_update_engine;

    localparam int W = 16;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, in_valid, load_en;
    logic [W-1:0]   error, rate_mul, load_data;
    logic [N*W-1:0] act;
    logic [5:0]     rate_shift;
    logic [1:0]     load_idx;

    logic           in_ready_s, done_s, sat_s, in_ready_w, done_w, sat_w;
    logic [N*W-1:0] weights_s, weights_w;

    logic           l3_en;
    logic [2:0]     l3_idx;
    logic [W-1:0]   l3_data;
    logic [5*W-1:0] weights3;
    logic           ready3, done3, sat3;

    weight_update_engine #(.WIDTH(W), .COUNT(N), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
        .error(error), .act(act), .rate_mul(rate_mul), .rate_shift(rate_shift),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
        .weights(weights_s), .done(done_s), .sat_flag(sat_s)
    );

    weight_update_engine #(.WIDTH(W), .COUNT(N), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .error(error), .act(act), .rate_mul(rate_mul), .rate_shift(rate_shift),
        .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
        .weights(weights_w), .done(done_w), .sat_flag(sat_w)
    );

    // Five-entry bank so that out-of-range load indices are expressible.
    weight_update_engine #(.WIDTH(W), .COUNT(5), .SATURATE(1)) dut_3 (
        .clk(clk), .reset(reset), .in_valid(1'b0), .in_ready(ready3),
        .error('0), .act('0), .rate_mul('0), .rate_shift('0),
        .load_en(l3_en), .load_idx(l3_idx), .load_data(l3_data),
        .weights(weights3), .done(done3), .sat_flag(sat3)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;

    // Model: index 0 = saturating instance, 1 = wrapping instance.
    longint mw [2][N];
    bit     msat [2];
    int     phase = 0;   // 0 idle, 1 running, 2 done cycle
    int     t = 0;       // number of the job cycle currently in progress
    longint m_err, m_rm;
    longint m_act [N];
    int     m_sh;

    task automatic chk(input string name, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic signed [63:0] el(input logic [5*W-1:0] v, input int i);
        logic [15:0] x;
        x = v[i*16 +: 16];
        return {{48{x[15]}}, x};
    endfunction

    function automatic longint sx16(input logic [15:0] v);
        return longint'($signed(v));
    endfunction

    task automatic apply(input int m, input int k);
        longint d, n;
        d = (m_err * m_act[k] * m_rm) >>> m_sh;
        n = mw[m][k] - d;
        if (m == 0) begin
            if (n > 32767) begin n = 32767; msat[0] = 1'b1; end
            else if (n < -32768) begin n = -32768; msat[0] = 1'b1; end
        end else begin
            n = n & 64'hFFFF;
            if (n > 32767) n = n - 65536;
        end
        mw[m][k] = n;
    endtask

    task automatic model_step();
        if (reset) begin
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < N; i++) mw[m][i] = 0;
                msat[m] = 1'b0;
            end
            phase = 0;
        end else begin
            case (phase)
                0: begin
                    if (load_en)
                        for (int m = 0; m < 2; m++) mw[m][load_idx] = sx16(load_data);
                    if (in_valid) begin
                        m_err = sx16(error);
                        m_rm  = sx16(rate_mul);
                        m_sh  = int'(rate_shift);
                        for (int i = 0; i < N; i++) m_act[i] = sx16(act[i*16 +: 16]);
                        msat[0] = 1'b0;
                        msat[1] = 1'b0;
                        phase = 1;
                        t = 1;
                    end
                end
                1: begin
                    if (t >= 2) begin
                        apply(0, t - 2);
                        apply(1, t - 2);
                    end
                    if (t == N + 1) phase = 2;
                    else t++;
                end
                default: phase = 0;
            endcase
        end
    endtask

    task automatic compare();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("w_sat[%0d]", i), el(80'(weights_s), i), mw[0][i]);
            chk($sformatf("w_wrap[%0d]", i), el(80'(weights_w), i), mw[1][i]);
        end
        chk("done_sat", 64'(done_s), 64'(phase == 2));
        chk("done_wrap", 64'(done_w), 64'(phase == 2));
        chk("sat_flag_sat", 64'(sat_s), 64'(msat[0]));
        chk("sat_flag_wrap", 64'(sat_w), 64'(msat[1]));
        chk("in_ready_sat", 64'(in_ready_s), 64'(phase == 0 && !reset));
        chk("in_ready_wrap", 64'(in_ready_w), 64'(phase == 0 && !reset));
        if (done_s === 1'b1) done_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare();
    endtask

    task automatic set_job(input longint e, input longint a0, input longint a1,
                           input longint a2, input longint a3, input longint rm, input int sh);
        error      = 16'(e);
        act        = {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
        rate_mul   = 16'(rm);
        rate_shift = 6'(sh);
        in_valid   = 1'b1;
    endtask

    // Acceptance edge, then scramble job inputs: the running job must ignore them.
    task automatic accept_job();
        tick();
        in_valid   = 1'b0;
        load_en    = 1'b0;
        error      = 16'($urandom);
        act        = {$urandom, $urandom};
        rate_mul   = 16'($urandom);
        rate_shift = 6'($urandom);
    endtask

    task automatic finish_job();
        repeat (N + 1) tick();
        chk("done_in_cycle_count_plus_2", 64'(done_s), 64'd1);
        tick();
        chk("done_single_cycle", 64'(done_s), 64'd0);
        chk("ready_after_done", 64'(in_ready_s), 64'd1);
    endtask

    task automatic load(input int idx, input longint v);
        load_en   = 1'b1;
        load_idx  = 2'(idx);
        load_data = 16'(v);
        tick();
        load_en   = 1'b0;
    endtask

    task automatic expect_bank(input string name, input longint e0, input longint e1,
                               input longint e2, input longint e3);
        longint e [N];
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", name, i), el(80'(weights_s), i), e[i]);
    endtask

    initial begin
        int dc;
        reset = 1'b1; in_valid = 1'b0; load_en = 1'b0; load_idx = '0; load_data = '0;
        error = '0; act = '0; rate_mul = '0; rate_shift = '0;
        l3_en = 1'b0; l3_idx = '0; l3_data = '0;
        tick();
        tick();
        reset = 1'b0;

        // Out-of-range load indices on the five-entry instance must be dropped.
        begin
            int     idxs [4] = '{0, 4, 5, 7};
            longint vals [4] = '{11, 77, 55, 66};
            longint e3 [5]   = '{11, 0, 0, 0, 77};
            for (int i = 0; i < 4; i++) begin
                l3_en = 1'b1; l3_idx = 3'(idxs[i]); l3_data = 16'(vals[i]);
                tick();
            end
            l3_en = 1'b0;
            for (int i = 0; i < 5; i++) chk($sformatf("bank5[%0d]", i), el(weights3, i), e3[i]);
            chk("bank5_ready", 64'(ready3), 64'd1);
            chk("bank5_done", 64'(done3), 64'd0);
            chk("bank5_sat", 64'(sat3), 64'd0);
        end

        // Basic job.
        load(0, 100); load(1, 200); load(2, -50); load(3, 0);
        dc = done_cnt;
        set_job(2, 3, -1, 0, 5, 1, 0);
        accept_job();
        finish_job();
        expect_bank("basic", 94, 202, -50, -10);
        chk("basic_sat_flag", 64'(sat_s), 64'd0);
        chk("basic_done_count", 64'(done_cnt - dc), 64'd1);

        // in_valid held high: second job waits until cycle 7 and sees first job's result.
        set_job(1, 1, 1, 1, 1, 1, 0);
        tick();
        repeat (5) tick();
        chk("b2b_ready_in_done_cycle", 64'(in_ready_s), 64'd0);
        tick();
        chk("b2b_ready_cycle7", 64'(in_ready_s), 64'd1);
        accept_job();
        finish_job();
        expect_bank("b2b", 92, 200, -52, -12);

        // Loads during RUN/DONE ignored; load in the accepting cycle is used by the job.
        set_job(0, 7, 7, 7, 7, 1, 0);
        accept_job();
        load_en = 1'b1; load_idx = 2'd1; load_data = 16'd999;
        repeat (6) tick();
        load_en = 1'b0;
        expect_bank("load_in_run", 92, 200, -52, -12);
        load_en = 1'b1; load_idx = 2'd0; load_data = 16'd50;
        set_job(1, 1, 0, 0, 0, 1, 0);
        accept_job();
        finish_job();
        expect_bank("load_with_accept", 49, 200, -52, -12);

        // Saturation versus wrap.
        load(0, 32000);
        set_job(-100, 100, 0, 0, 0, 1, 0);
        accept_job();
        finish_job();
        chk("sat_clamp_value", el(80'(weights_s), 0), 32767);
        chk("sat_flag_set", 64'(sat_s), 64'd1);
        chk("wrap_value", el(80'(weights_w), 0), -23536);
        chk("wrap_flag_clear", 64'(sat_w), 64'd0);
        repeat (3) tick();
        chk("sat_flag_sticky", 64'(sat_s), 64'd1);
        set_job(0, 0, 0, 0, 0, 1, 0);
        accept_job();
        chk("sat_flag_cleared_on_accept", 64'(sat_s), 64'd0);
        finish_job();

        // Floor rounding of the arithmetic shift.
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        set_job(1, 3, -3, 1, -1, 1, 1);
        accept_job();
        finish_job();
        expect_bank("floor", -1, 2, 0, 1);
        for (int i = 0; i < N; i++)
            chk($sformatf("floor_wrap[%0d]", i), el(80'(weights_w), i), el(80'(weights_s), i) == 0 ?
                64'sd0 : mw[1][i]);

        // Reset in cycle 3 aborts the job.
        set_job(1, 1, 1, 1, 1, 1, 0);
        accept_job();
        tick();
        tick();
        chk("abort_partial_write", el(80'(weights_s), 0), -2);
        reset = 1'b1;
        dc = done_cnt;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_ready_after_reset", 64'(in_ready_s), 64'd1);
        expect_bank("abort", 0, 0, 0, 0);
        repeat (8) tick();
        chk("abort_no_done", 64'(done_cnt - dc), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
